// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter for one shared selection resource: registered one-hot grant plus
// encoded select, with hold-while-requested ownership and timeout-driven rotation.
module rr_port_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   select,
    output logic               preempt,
    output logic [4:0]         hold_cnt,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_REVOKE = 2'd2
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
    localparam bit                 PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [4:0]         HOLD_MAX   = 5'd31;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [SEL_W-1:0]     select_q, select_d;
    logic                 preempt_q, preempt_d;
    logic [4:0]           hold_cnt_q, hold_cnt_d;

    // Returns {found, index}: first set bit of mask scanning upward from start, wrapping.
    // NUM_REQ is a power of two, so SEL_W-bit addition wraps modulo NUM_REQ for free.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [SEL_W-1:0]   start);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [SEL_W:0]     pick_ptr;
    logic [SEL_W:0]     pick_rel;
    logic [SEL_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] others;
    logic               holder_req;
    logic               timeout;

    assign next_ptr   = select_q + SEL_W'(1);
    assign others     = req & ~grant_q;
    assign holder_req = req[select_q];
    // The holder is excluded from the release search so it cannot re-win its own slot.
    assign pick_ptr   = rr_pick(req, ptr_q);
    assign pick_rel   = rr_pick(others, next_ptr);
    assign timeout    = PREEMPT_EN && (int'(hold_cnt_q) >= MAX_HOLD - 1) && (|others);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        select_d      = select_q;
        preempt_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_REVOKE: begin
                // In REVOKE, ptr already points past the preempted holder, so it ranks last.
                if (pick_ptr[SEL_W]) begin
                    grant_d       = ONE_HOT0 << pick_ptr[SEL_W-1:0];
                    select_d      = pick_ptr[SEL_W-1:0];
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_GRANT;
                end else begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    state_d       = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (holder_req) begin
                    if (timeout) begin
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        preempt_d     = 1'b1;
                        ptr_d         = next_ptr;
                        hold_cnt_d    = '0;
                        state_d       = ST_REVOKE;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 5'd1;
                    end
                end else begin
                    ptr_d      = next_ptr;
                    hold_cnt_d = '0;
                    if (pick_rel[SEL_W]) begin
                        grant_d  = ONE_HOT0 << pick_rel[SEL_W-1:0];
                        select_d = pick_rel[SEL_W-1:0];
                    end else begin
                        // select keeps its last value so the shared mux stays quiet.
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            select_q      <= '0;
            preempt_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            select_q      <= select_d;
            preempt_q     <= preempt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign select      = select_q;
    assign preempt     = preempt_q;
    assign hold_cnt    = hold_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: hand-computed grant/select/preempt/hold_cnt vectors.
module tb_rr_port_arbiter;

    logic       clock;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] select;
    logic       preempt;
    logic [4:0] hold_cnt;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    rr_port_arbiter #(.NUM_REQ(8), .SEL_W(3), .MAX_HOLD(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .select      (select),
        .preempt     (preempt),
        .hold_cnt    (hold_cnt),
        .dbg_state   (dbg_state)
    );

    // Clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are inspected 1 time unit after the active edge; inputs change there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic gv,
                              input logic [2:0] s, input logic p, input logic [4:0] h);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        check_eq({tag, ".select"}, 32'(select), 32'(s));
        check_eq({tag, ".preempt"}, 32'(preempt), 32'(p));
        check_eq({tag, ".hold_cnt"}, 32'(hold_cnt), 32'(h));
    endtask

    initial begin
        int owners[4];
        logic [7:0] oh;
        owners = '{2, 5, 2, 5};
        reset  = 1'b1;
        req    = 8'h00;

        // Reset state, then idle with no requests
        do_reset();
        expect_out("reset", 8'h00, 1'b0, 3'd0, 1'b0, 5'd0);
        check_eq("reset.state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("idle", 8'h00, 1'b0, 3'd0, 1'b0, 5'd0);
        end

        // Single request, release, then pointer moved to 1
        req = 8'h01;
        step();
        expect_out("single", 8'h01, 1'b1, 3'd0, 1'b0, 5'd0);
        req = 8'h00;
        step();
        expect_out("release", 8'h00, 1'b0, 3'd0, 1'b0, 5'd0);
        req = 8'h03;
        step();
        expect_out("ptr1", 8'h02, 1'b1, 3'd1, 1'b0, 5'd0);
        req = 8'h00;
        step();
        expect_out("ptr1_rel", 8'h00, 1'b0, 3'd1, 1'b0, 5'd0);

        // Alternating owners 2,5,2,5 with zero-bubble handoff
        do_reset();
        req = 8'h24;
        for (int o = 0; o < 4; o++) begin
            oh = 8'h01 << owners[o];
            for (int k = 1; k <= 3; k++) begin
                step();
                expect_out($sformatf("alt%0d", o), oh, 1'b1, 3'(owners[o]), 1'b0, 5'(k - 1));
                if (k == 1) req = 8'h24;
                if (k == 3) req = 8'h24 & ~oh;
            end
        end
        step();
        expect_out("alt_last", 8'h04, 1'b1, 3'd2, 1'b0, 5'd0);
        req = 8'h00;
        step();
        expect_out("alt_idle", 8'h00, 1'b0, 3'd2, 1'b0, 5'd0);

        // Timeout preemption between 0 and 7
        do_reset();
        req = 8'h81;
        for (int k = 0; k < 16; k++) begin
            step();
            expect_out("hold0", 8'h01, 1'b1, 3'd0, 1'b0, 5'(k));
        end
        step();
        expect_out("revoke0", 8'h00, 1'b0, 3'd0, 1'b1, 5'd0);
        check_eq("revoke0.state", 32'(dbg_state), 32'd2);
        step();
        expect_out("own7", 8'h80, 1'b1, 3'd7, 1'b0, 5'd0);
        for (int k = 1; k < 16; k++) begin
            step();
            expect_out("hold7", 8'h80, 1'b1, 3'd7, 1'b0, 5'(k));
        end
        step();
        expect_out("revoke7", 8'h00, 1'b0, 3'd7, 1'b1, 5'd0);
        step();
        expect_out("back0", 8'h01, 1'b1, 3'd0, 1'b0, 5'd0);

        // Lone holder: no preemption, hold_cnt saturates
        do_reset();
        req = 8'h08;
        for (int k = 0; k < 40; k++) begin
            step();
            expect_out("lone", 8'h08, 1'b1, 3'd3, 1'b0, (k > 31) ? 5'd31 : 5'(k));
        end

        // Reset mid-grant with a non-zero pointer
        do_reset();
        req = 8'h20;
        step();
        expect_out("pre_rst_a", 8'h20, 1'b1, 3'd5, 1'b0, 5'd0);
        req = 8'h00;
        step();
        expect_out("pre_rst_b", 8'h00, 1'b0, 3'd5, 1'b0, 5'd0);
        req = 8'h20;
        step();
        step();
        expect_out("pre_rst_c", 8'h20, 1'b1, 3'd5, 1'b0, 5'd1);
        reset = 1'b1;
        step();
        expect_out("mid_rst", 8'h00, 1'b0, 3'd0, 1'b0, 5'd0);
        check_eq("mid_rst.state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        req   = 8'hFF;
        step();
        expect_out("post_rst", 8'h01, 1'b1, 3'd0, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_port_arbiter.md
Name: rr_port_arbiter

Overview:
- Round-robin arbiter that shares one wide selection resource (e.g. a 128:1 bit-select mux or a register-file read port) among NUM_REQ requesters.
- Drives the encoded select value and a one-hot grant.
- Holds a grant while its requester keeps req high.
- Forcibly rotates ownership after MAX_HOLD cycles when another requester is waiting, so no client starves.

Parameters:
NUM_REQ, 8, number of requesters; power of two, 2..16
SEL_W, 3, width of encoded select; equals log2(NUM_REQ)
MAX_HOLD, 16, cycles a holder may keep the grant while others wait; 0 disables preemption

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high for the whole duration of use
grant  output  NUM_REQ  one-hot grant, registered; all zero when no owner
grant_valid  output  1  high when grant has exactly one bit set
select  output  SEL_W  encoded index of the current owner; drives the shared mux select
preempt  output  1  one-cycle pulse in the cycle the grant is revoked by timeout
hold_cnt  output  5  cycles the current owner has held the grant; saturates at 31

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values, while reset is high at a clock edge:
  - state IDLE, ptr 0
  - grant 0, grant_valid 0, select 0, preempt 0, hold_cnt 0
  - Reset overrides every other event, including mid-grant.
- Priority pointer ptr (SEL_W bits): the search starts at index ptr and proceeds upward, wrapping modulo NUM_REQ. The first set req wins.
- States: IDLE, GRANT, REVOKE.
- IDLE:
  - Any req high -> winner chosen combinationally from the current req.
  - Next edge: grant = onehot(winner), select = winner, grant_valid = 1, hold_cnt = 0, state GRANT.
  - Latency from req to grant is 1 cycle.
- GRANT, holder's req still high:
  - hold_cnt increments each cycle, saturating at 31.
  - select and grant stay stable.
- GRANT, holder's req low (release):
  - ptr = select+1 mod NUM_REQ.
  - Arbitrate the same cycle among the remaining reqs, searching from the new ptr and excluding the releasing index.
  - Winner -> new grant at the next edge (zero bubble), hold_cnt = 0.
  - No winner -> grant 0, grant_valid 0, state IDLE; select holds its last value.
- GRANT, timeout (MAX_HOLD != 0, hold_cnt >= MAX_HOLD-1, holder req still high, and some other req high):
  - Next edge: grant 0, grant_valid 0, preempt 1, ptr = select+1, state REVOKE.
- REVOKE:
  - Lasts one cycle; gives the shared resource a dead cycle so the mux output settles.
  - preempt returns to 0.
  - Arbitrate from ptr; the preempted holder is eligible, but only after all others in rotation.
  - Grant is issued at the next edge; if no req is high, go to IDLE.
- Timeout with no other requester waiting: no preemption; the holder keeps the grant indefinitely and hold_cnt saturates.
- A requester that drops req in the same cycle it would be granted:
  - It is still granted for one cycle.
  - Its release is then detected and handled normally.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - When grant_valid = 1, select == index of the grant bit.
- Requests from non-owners may toggle freely; they have no effect until arbitration.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant 0, grant_valid 0, select 0, preempt 0 throughout.
- req=8'h01 from IDLE -> next cycle grant=8'h01, select=0, grant_valid=1; drop req -> grant 0 the next cycle and ptr=1 (a subsequent req=8'h03 grants index 1 first).
- req=8'h24 held, each holder releasing after 3 cycles -> grants alternate 2,5,2,5 with no idle cycle between owners; select always matches grant.
- MAX_HOLD=16, req=8'h81 held continuously -> owner 0 holds 16 cycles; preempt pulses; one REVOKE cycle with grant 0; grant=8'h80, select=7. After 16 more cycles, back to index 0.
- MAX_HOLD=16, only req[3] high for 40 cycles -> no preempt; hold_cnt saturates at 31; grant stays 8'h08.
- Assert reset while in GRANT (select=5) -> next edge all outputs return to reset values. After release, req=8'hFF -> grant=8'h01 (ptr reset to 0).
